// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the memory port arbiter: FSM states, grant IDs and the
// watchdog counter width helper.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2,
        ERR  = 2'd3
    } arb_state_t;

    typedef enum logic {
        GNT_IF  = 1'b0,
        GNT_MEM = 1'b1
    } gnt_id_t;

    // Counter must hold TIMEOUT; keep at least one bit so a disabled
    // watchdog (TIMEOUT = 0) still elaborates.
    function automatic int wd_cnt_width(input int timeout);
        return (timeout < 1) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/mem_port_arbiter_bus_watchdog.sv
// Clear/enable saturating cycle counter. 'expired' is raised during the
// cycle whose closing edge would bring the count to TIMEOUT, so the owner
// can leave its busy state after exactly TIMEOUT busy cycles.
module bus_watchdog
    import mem_arb_pkg::*;
#(
    parameter int TIMEOUT = 256
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CNT_W = wd_cnt_width(TIMEOUT);

    logic [CNT_W-1:0] count_reg;

    // Count busy cycles, clear on request, saturate at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
        end else if (clr) begin
            count_reg <= '0;
        end else if (en && (count_reg != '1)) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    generate
        if (TIMEOUT == 0) begin : g_off
            assign expired = 1'b0;
        end else begin : g_on
            assign expired = en && (count_reg >= CNT_W'(TIMEOUT - 1));
        end
    endgenerate

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory bus between instruction fetch and the load/store path.
// One transaction in flight, all bus outputs registered, completions are
// reported with a one-cycle valid pulse. Data requests win over fetch.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 256
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_if_req,
    input  logic [ADDR_W-1:0]   i_if_addr,
    output logic [DATA_W-1:0]   o_if_rdata,
    output logic                o_if_valid,
    input  logic                i_mem_ren,
    input  logic                i_mem_wen,
    input  logic [ADDR_W-1:0]   i_mem_addr,
    input  logic [DATA_W-1:0]   i_mem_wdata,
    input  logic [DATA_W/8-1:0] i_mem_mask,
    output logic [DATA_W-1:0]   o_mem_rdata,
    output logic                o_mem_valid,
    output logic                o_bus_req,
    output logic                o_bus_we,
    output logic [ADDR_W-1:0]   o_bus_addr,
    output logic [DATA_W-1:0]   o_bus_wdata,
    output logic [DATA_W/8-1:0] o_bus_mask,
    input  logic                i_bus_ready,
    input  logic                i_bus_rvalid,
    input  logic [DATA_W-1:0]   i_bus_rdata,
    output logic                o_stall,
    output logic                o_bus_err
);

    localparam int MASK_W = DATA_W / 8;

    arb_state_t        state_reg;
    gnt_id_t           gnt_reg;
    logic              data_req;
    logic              fetch_req;
    logic              wd_busy;
    logic              wd_idle;
    logic              wd_expired;
    logic [MASK_W-1:0] data_mask;

    // A requester still holding its line during its own completion cycle
    // must not be granted again, hence the masking by the valid pulse.
    assign data_req  = (i_mem_ren | i_mem_wen) & ~o_mem_valid;
    assign fetch_req = i_if_req & ~o_if_valid;
    assign o_stall   = fetch_req | data_req | (state_reg == ERR);

    assign wd_busy = (state_reg == REQ) || (state_reg == RESP);
    assign wd_idle = (state_reg == IDLE);

    // Reads always enable every byte lane; writes (including ren+wen) use
    // the requester's byte enables.
    genvar gi;
    generate
        for (gi = 0; gi < MASK_W; gi++) begin : g_mask
            assign data_mask[gi] = i_mem_wen ? i_mem_mask[gi] : 1'b1;
        end
    endgenerate

    bus_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk     (i_clk),
        .rst     (i_rst),
        .clr     (wd_idle),
        .en      (wd_busy),
        .expired (wd_expired)
    );

    // Arbitration/sequencing FSM with all outputs registered.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_reg   <= IDLE;
            gnt_reg     <= GNT_IF;
            o_bus_req   <= 1'b0;
            o_bus_we    <= 1'b0;
            o_bus_addr  <= '0;
            o_bus_wdata <= '0;
            o_bus_mask  <= '0;
            o_if_rdata  <= '0;
            o_if_valid  <= 1'b0;
            o_mem_rdata <= '0;
            o_mem_valid <= 1'b0;
            o_bus_err   <= 1'b0;
        end else begin
            o_if_valid  <= 1'b0;
            o_mem_valid <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (data_req) begin
                        gnt_reg     <= GNT_MEM;
                        o_bus_req   <= 1'b1;
                        o_bus_we    <= i_mem_wen;
                        o_bus_addr  <= i_mem_addr;
                        o_bus_wdata <= i_mem_wdata;
                        o_bus_mask  <= data_mask;
                        state_reg   <= REQ;
                    end else if (fetch_req) begin
                        gnt_reg     <= GNT_IF;
                        o_bus_req   <= 1'b1;
                        o_bus_we    <= 1'b0;
                        o_bus_addr  <= i_if_addr;
                        o_bus_wdata <= '0;
                        o_bus_mask  <= '1;
                        state_reg   <= REQ;
                    end
                end
                REQ: begin
                    // The bus had its full allowance; an accept in the
                    // expiring cycle still counts as too late.
                    if (wd_expired) begin
                        o_bus_req <= 1'b0;
                        o_bus_err <= 1'b1;
                        state_reg <= ERR;
                    end else if (i_bus_ready) begin
                        o_bus_req <= 1'b0;
                        state_reg <= RESP;
                    end
                end
                RESP: begin
                    // A response in the last allowed cycle completes normally.
                    if (i_bus_rvalid) begin
                        state_reg <= IDLE;
                        if (gnt_reg == GNT_IF) begin
                            o_if_rdata <= i_bus_rdata;
                            o_if_valid <= 1'b1;
                        end else begin
                            o_mem_valid <= 1'b1;
                            if (!o_bus_we) begin
                                o_mem_rdata <= i_bus_rdata;
                            end
                        end
                    end else if (wd_expired) begin
                        o_bus_err <= 1'b1;
                        state_reg <= ERR;
                    end
                end
                ERR: begin
                    o_bus_req <= 1'b0;
                    o_bus_err <= 1'b1;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: directed scenarios followed by random
// rounds against a reactive bus slave; completions are checked by a
// scoreboard monitor fed from the stimulus side.
module tb_mem_port_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MW = DW / 8;
    localparam int TO = 8;

    logic          i_clk = 1'b0;
    logic          i_rst;
    logic          i_if_req;
    logic [AW-1:0] i_if_addr;
    logic [DW-1:0] o_if_rdata;
    logic          o_if_valid;
    logic          i_mem_ren;
    logic          i_mem_wen;
    logic [AW-1:0] i_mem_addr;
    logic [DW-1:0] i_mem_wdata;
    logic [MW-1:0] i_mem_mask;
    logic [DW-1:0] o_mem_rdata;
    logic          o_mem_valid;
    logic          o_bus_req;
    logic          o_bus_we;
    logic [AW-1:0] o_bus_addr;
    logic [DW-1:0] o_bus_wdata;
    logic [MW-1:0] o_bus_mask;
    logic          i_bus_ready;
    logic          i_bus_rvalid;
    logic [DW-1:0] i_bus_rdata;
    logic          o_stall;
    logic          o_bus_err;

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [MW-1:0] mask;
    } bus_exp_t;

    typedef struct {
        logic          is_mem;
        logic [DW-1:0] rdata;
    } done_exp_t;

    bus_exp_t  bus_q[$];
    done_exp_t done_q[$];
    int        total = 0;
    int        bad = 0;
    bit        slave_on = 1'b0;
    logic [DW-1:0] last_mem = '0;

    mem_port_arbiter #(
        .ADDR_W  (AW),
        .DATA_W  (DW),
        .TIMEOUT (TO)
    ) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_if_req     (i_if_req),
        .i_if_addr    (i_if_addr),
        .o_if_rdata   (o_if_rdata),
        .o_if_valid   (o_if_valid),
        .i_mem_ren    (i_mem_ren),
        .i_mem_wen    (i_mem_wen),
        .i_mem_addr   (i_mem_addr),
        .i_mem_wdata  (i_mem_wdata),
        .i_mem_mask   (i_mem_mask),
        .o_mem_rdata  (o_mem_rdata),
        .o_mem_valid  (o_mem_valid),
        .o_bus_req    (o_bus_req),
        .o_bus_we     (o_bus_we),
        .o_bus_addr   (o_bus_addr),
        .o_bus_wdata  (o_bus_wdata),
        .o_bus_mask   (o_bus_mask),
        .i_bus_ready  (i_bus_ready),
        .i_bus_rvalid (i_bus_rvalid),
        .i_bus_rdata  (i_bus_rdata),
        .o_stall      (o_stall),
        .o_bus_err    (o_bus_err)
    );

    always #5 i_clk = ~i_clk;

    // Memory contents seen by reads: a fixed scramble of the address.
    function automatic logic [DW-1:0] rmodel(input logic [AW-1:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h5A5A_0F0F;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic push_done(input logic is_mem, input logic [DW-1:0] d);
        done_exp_t e;
        e.is_mem = is_mem;
        e.rdata  = d;
        done_q.push_back(e);
    endtask

    task automatic check_bus(input bus_exp_t e);
        check("bus_req", o_bus_req, 1'b1);
        check("bus_we", o_bus_we, e.we);
        check("bus_addr", o_bus_addr, e.addr);
        check("bus_mask", o_bus_mask, e.mask);
        if (e.we) check("bus_wdata", o_bus_wdata, e.wdata);
    endtask

    // Scoreboard monitor: every completion pulse must match the next
    // expected completion in issue order.
    task automatic monitor_loop();
        done_exp_t e;
        forever begin
            @(negedge i_clk);
            if (o_if_valid || o_mem_valid) begin
                if (done_q.size() == 0) begin
                    check("valid_unexpected", {o_if_valid, o_mem_valid}, 2'b00);
                end else begin
                    e = done_q.pop_front();
                    check("done_port", {o_if_valid, o_mem_valid}, {~e.is_mem, e.is_mem});
                    if (e.is_mem) check("mem_rdata", o_mem_rdata, e.rdata);
                    else          check("if_rdata", o_if_rdata, e.rdata);
                    $display("done %s rdata=%08h", e.is_mem ? "mem" : "if ", e.is_mem ? o_mem_rdata : o_if_rdata);
                end
            end
        end
    endtask

    // Serve one granted bus request with random ready/rvalid waits and
    // stray rvalids while still in the request phase.
    task automatic serve();
        bus_exp_t e;
        int rd;
        int vd;
        if (bus_q.size() == 0) begin
            check("bus_req_unexpected", o_bus_req, 1'b0);
            return;
        end
        e  = bus_q.pop_front();
        rd = $urandom_range(0, 2);
        vd = $urandom_range(0, 2);
        check_bus(e);
        repeat (rd) begin
            i_bus_rvalid = 1'($urandom_range(0, 1));
            tick();
            check_bus(e);
        end
        i_bus_rvalid = 1'b0;
        i_bus_ready  = 1'b1;
        tick();
        i_bus_ready = 1'b0;
        check("bus_req_drop", o_bus_req, 1'b0);
        repeat (vd) tick();
        i_bus_rvalid = 1'b1;
        i_bus_rdata  = e.we ? $urandom() : rmodel(e.addr);
        tick();
        i_bus_rvalid = 1'b0;
        $display("bus %s addr=%08h ready_wait=%0d rvalid_wait=%0d", e.we ? "wr" : "rd", e.addr, rd, vd);
    endtask

    task automatic slave_loop();
        forever begin
            tick();
            if (slave_on && o_bus_req) serve();
        end
    endtask

    // Issue one round of requests (data and/or fetch), hold each until its
    // completion pulse, bounded by a cycle budget.
    task automatic run_round(input bit do_if, input bit do_mem, input int op,
                             input logic [AW-1:0] a_if, input logic [AW-1:0] a_mem,
                             input logic [DW-1:0] wd, input logic [MW-1:0] mk);
        bus_exp_t b;
        int cyc = 0;
        if (do_mem) begin
            b.we    = (op != 0);
            b.addr  = a_mem;
            b.wdata = wd;
            b.mask  = b.we ? mk : '1;
            bus_q.push_back(b);
            if (!b.we) last_mem = rmodel(a_mem);
            push_done(1'b1, last_mem);
            i_mem_ren   = (op != 1);
            i_mem_wen   = (op != 0);
            i_mem_addr  = a_mem;
            i_mem_wdata = wd;
            i_mem_mask  = mk;
        end
        if (do_if) begin
            b.we    = 1'b0;
            b.addr  = a_if;
            b.wdata = '0;
            b.mask  = '1;
            bus_q.push_back(b);
            push_done(1'b0, rmodel(a_if));
            i_if_req  = 1'b1;
            i_if_addr = a_if;
        end
        while ((i_if_req || i_mem_ren || i_mem_wen) && cyc < 40) begin
            tick();
            cyc++;
            if (o_mem_valid) begin
                i_mem_ren = 1'b0;
                i_mem_wen = 1'b0;
            end
            if (o_if_valid) i_if_req = 1'b0;
        end
        check("round_complete", {i_if_req, i_mem_ren, i_mem_wen}, 3'b000);
        i_if_req  = 1'b0;
        i_mem_ren = 1'b0;
        i_mem_wen = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int n;
        i_rst = 1'b1; i_if_req = 1'b0; i_if_addr = '0;
        i_mem_ren = 1'b0; i_mem_wen = 1'b0; i_mem_addr = '0; i_mem_wdata = '0; i_mem_mask = '0;
        i_bus_ready = 1'b0; i_bus_rvalid = 1'b0; i_bus_rdata = '0;
        fork
            monitor_loop();
            slave_loop();
        join_none

        // Reset state
        repeat (3) tick();
        check("rst_outputs", {o_bus_req, o_bus_we, o_if_valid, o_mem_valid, o_bus_err, o_stall}, 6'b0);
        check("rst_bus_addr", o_bus_addr, 0);
        check("rst_bus_mask", o_bus_mask, 0);
        check("rst_rdata", {o_if_rdata, o_mem_rdata}, 64'h0);
        i_rst = 1'b0;
        tick();

        // Fetch, zero-wait bus
        i_if_req = 1'b1; i_if_addr = 32'h40;
        push_done(1'b0, 32'h13);
        #1 check("t1_stall_c0", o_stall, 1'b1);
        tick();
        check("t1_req_c1", o_bus_req, 1'b1);
        check("t1_addr_c1", o_bus_addr, 32'h40);
        check("t1_we_c1", o_bus_we, 1'b0);
        check("t1_stall_c1", o_stall, 1'b1);
        i_bus_ready = 1'b1;
        tick();
        i_bus_ready = 1'b0;
        check("t1_req_c2", o_bus_req, 1'b0);
        check("t1_stall_c2", o_stall, 1'b1);
        i_bus_rvalid = 1'b1; i_bus_rdata = 32'h13;
        tick();
        i_bus_rvalid = 1'b0;
        check("t1_valid_c3", o_if_valid, 1'b1);
        check("t1_rdata_c3", o_if_rdata, 32'h13);
        check("t1_stall_c3", o_stall, 1'b0);
        i_if_req = 1'b0;
        tick();
        check("t1_valid_c4", o_if_valid, 1'b0);

        // Simultaneous store and fetch: store first, fetch granted in the
        // store's completion cycle
        i_if_req = 1'b1; i_if_addr = 32'h80;
        i_mem_wen = 1'b1; i_mem_addr = 32'h100; i_mem_wdata = 32'hDEADBEEF; i_mem_mask = 4'hF;
        push_done(1'b1, last_mem);
        push_done(1'b0, 32'h0BADF00D);
        tick();
        check("t2_we_c1", o_bus_we, 1'b1);
        check("t2_addr_c1", o_bus_addr, 32'h100);
        check("t2_wdata_c1", o_bus_wdata, 32'hDEADBEEF);
        check("t2_mask_c1", o_bus_mask, 4'hF);
        i_bus_ready = 1'b1;
        tick();
        i_bus_ready = 1'b0; i_bus_rvalid = 1'b1; i_bus_rdata = 32'h0;
        tick();
        i_bus_rvalid = 1'b0;
        check("t2_mem_valid_c3", o_mem_valid, 1'b1);
        i_mem_wen = 1'b0;
        tick();
        check("t2_fetch_req_c4", o_bus_req, 1'b1);
        check("t2_fetch_addr_c4", o_bus_addr, 32'h80);
        check("t2_fetch_we_c4", o_bus_we, 1'b0);
        i_bus_ready = 1'b1;
        tick();
        i_bus_ready = 1'b0; i_bus_rvalid = 1'b1; i_bus_rdata = 32'h0BADF00D;
        tick();
        i_bus_rvalid = 1'b0;
        check("t2_if_valid_c6", o_if_valid, 1'b1);
        i_if_req = 1'b0;
        tick();

        // Load with 2 ready waits and 3 rvalid waits, stray rvalid in REQ
        i_mem_ren = 1'b1; i_mem_addr = 32'h200; i_mem_wdata = 32'h1111_2222; i_mem_mask = 4'h0;
        last_mem = 32'h12345678;
        push_done(1'b1, last_mem);
        for (int c = 1; c <= 7; c++) begin
            tick();
            i_bus_ready  = (c == 3);
            i_bus_rvalid = (c == 1) || (c == 7);
            i_bus_rdata  = 32'h12345678;
            check("t3_req", o_bus_req, (c <= 3));
            check("t3_addr", o_bus_addr, 32'h200);
            check("t3_mask", o_bus_mask, 4'hF);
            check("t3_valid_early", o_mem_valid, 1'b0);
        end
        tick();
        i_bus_rvalid = 1'b0;
        check("t3_valid_c8", o_mem_valid, 1'b1);
        check("t3_rdata_c8", o_mem_rdata, 32'h12345678);
        i_mem_ren = 1'b0;
        tick();
        check("t3_valid_c9", o_mem_valid, 1'b0);

        // ren and wen together: a write, load data left untouched
        i_mem_ren = 1'b1; i_mem_wen = 1'b1; i_mem_addr = 32'h300;
        i_mem_wdata = 32'hCAFEF00D; i_mem_mask = 4'h3;
        push_done(1'b1, last_mem);
        tick();
        check("t6_we", o_bus_we, 1'b1);
        check("t6_addr", o_bus_addr, 32'h300);
        check("t6_mask", o_bus_mask, 4'h3);
        i_bus_ready = 1'b1;
        tick();
        i_bus_ready = 1'b0; i_bus_rvalid = 1'b1; i_bus_rdata = 32'hFFFF_FFFF;
        tick();
        i_bus_rvalid = 1'b0;
        check("t6_valid", o_mem_valid, 1'b1);
        check("t6_rdata_hold", o_mem_rdata, 32'h12345678);
        i_mem_ren = 1'b0; i_mem_wen = 1'b0;
        tick();

        // Reset during RESP, then a late rvalid must be ignored
        i_if_req = 1'b1; i_if_addr = 32'h44;
        tick();
        i_bus_ready = 1'b1;
        tick();
        i_bus_ready = 1'b0;
        i_rst = 1'b1;
        #1;
        check("t5_async_ctl", {o_bus_req, o_bus_we, o_if_valid, o_mem_valid, o_bus_err}, 5'b0);
        check("t5_async_rdata", {o_if_rdata, o_mem_rdata}, 64'h0);
        check("t5_async_addr", o_bus_addr, 0);
        i_if_req = 1'b0;
        last_mem = '0;
        tick();
        i_rst = 1'b0;
        i_bus_rvalid = 1'b1; i_bus_rdata = 32'h7777_7777;
        tick();
        i_bus_rvalid = 1'b0;
        check("t5_no_valid", {o_if_valid, o_mem_valid, o_bus_req}, 3'b000);
        tick();

        // Normal operation after reset, then random rounds
        slave_on = 1'b1;
        run_round(1'b1, 1'b0, 0, 32'h44, '0, '0, '0);
        for (int r = 0; r < 40; r++) begin
            int sel;
            sel = $urandom_range(1, 3);
            run_round(sel[0], sel[1], $urandom_range(0, 2), $urandom() & 32'hFFFF_FFFC,
                      $urandom(), $urandom(), 4'($urandom_range(0, 15)));
            repeat ($urandom_range(0, 2)) tick();
        end
        slave_on = 1'b0;
        tick();

        // Watchdog: ready never comes
        i_mem_ren = 1'b1; i_mem_addr = 32'h400;
        n = 0;
        do begin
            tick();
            n++;
        end while (!o_bus_err && n < 20);
        check("t4_timeout_cycle", n, 9);
        check("t4_err_stall", o_stall, 1'b1);
        check("t4_err_req", o_bus_req, 1'b0);
        i_mem_ren = 1'b0; i_if_req = 1'b1; i_if_addr = 32'h500;
        repeat (4) begin
            tick();
            check("t4_no_grant", o_bus_req, 1'b0);
            check("t4_err_sticky", o_bus_err, 1'b1);
        end
        check("t4_stall_in_err", o_stall, 1'b1);
        i_rst = 1'b1;
        #1;
        check("t4_rst_err", o_bus_err, 1'b0);
        i_if_req = 1'b0;
        tick();
        i_rst = 1'b0;
        #1 check("t4_rst_stall", o_stall, 1'b0);
        slave_on = 1'b1;
        run_round(1'b1, 1'b0, 0, 32'h600, '0, '0, '0);
        slave_on = 1'b0;
        repeat (2) tick();

        check("bus_q_drained", bus_q.size(), 0);
        check("done_q_drained", done_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
